bip_fetch_control: RTL and testbench

Upstream fetch/sequencing stage of the BIP processor. Owns the program counter and instruction register, and reads 16-bit instructions from a synchronous program memory. Presents the 5-bit opcode to the instruction decoder and consumes the decoder's WrPC to advance. Also provides start/halt handshaking and a clock-cycle counter for reporting execution time.

---
 rtl/bip_fetch_control.sv | 82 ++++++++
 tb/tb_bip_fetch_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_fetch_control.sv
// BIP fetch/sequencing stage: program counter, instruction register and run control.
// Each instruction takes FETCH -> WAIT -> EXEC with no overlap; a cycle counter times the run.
module bip_fetch_control #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [PC_WIDTH-1:0]  prog_addr,
  output logic                 prog_rd,
  input  logic [15:0]          prog_data,
  input  logic                 wr_pc,
  output logic [4:0]           opcode,
  output logic [10:0]          operand,
  output logic                 instr_valid,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, HALT} state_t;

  state_t               state, nextState;
  logic [PC_WIDTH-1:0]  pc;
  logic [15:0]          ir;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 launch;
  logic                 isHlt;

  assign launch = start && (state == IDLE || state == HALT);
  assign isHlt  = (ir[15:11] == 5'b00000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = FETCH;
      FETCH:   nextState = WAIT;
      WAIT:    nextState = EXEC;
      EXEC:    nextState = isHlt ? HALT : FETCH;
      HALT:    if (start) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    prog_rd     = (state == FETCH);
    instr_valid = (state == EXEC);
    busy        = (state == FETCH) || (state == WAIT) || (state == EXEC);
    halted      = (state == HALT);
  end

  // A stalled EXEC (wr_pc low) leaves pc alone, so the next FETCH rereads the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  pc <= '0;
    else if (launch)                          pc <= '0;
    else if (state == EXEC && !isHlt && wr_pc) pc <= pc + PC_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ir <= '0;
    else if (state == WAIT) ir <= prog_data;
  end

  // Saturating so very long runs report "at least" rather than a wrapped small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (launch) cnt <= '0;
    else if (busy && cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + CNT_WIDTH'(1);
  end

  assign prog_addr   = pc;
  assign opcode      = ir[15:11];
  assign operand     = ir[10:0];
  assign cycle_count = cnt;

endmodule

// File: tb/tb_bip_fetch_control.sv
// Directed bench for bip_fetch_control: fetch/exec events are checked against a scoreboard
// of expected (cycle, address) and (cycle, opcode) entries; state and counters are checked directly.
module tb_bip_fetch_control;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: small PC for wrap test, full-width counter
  logic        startA = 1'b0, stallA = 1'b0;
  logic [2:0]  progAddrA;
  logic        progRdA, wrPcA, instrValidA, busyA, haltedA;
  logic [15:0] progDataA;
  logic [4:0]  opcodeA;
  logic [10:0] operandA;
  logic [31:0] cntA;
  logic [15:0] memA [8];
  int          baseA = 0;

  // instance B: default PC width, 4-bit counter for saturation
  logic        startB = 1'b0;
  logic [10:0] progAddrB;
  logic        progRdB, wrPcB, instrValidB, busyB, haltedB;
  logic [15:0] progDataB;
  logic [4:0]  opcodeB;
  logic [10:0] operandB;
  logic [3:0]  cntB;
  logic [15:0] memB [8];

  bip_fetch_control #(.PC_WIDTH(3), .CNT_WIDTH(32)) dutA (
    .clk(clk), .rst(rst), .start(startA), .prog_addr(progAddrA), .prog_rd(progRdA),
    .prog_data(progDataA), .wr_pc(wrPcA), .opcode(opcodeA), .operand(operandA),
    .instr_valid(instrValidA), .busy(busyA), .halted(haltedA), .cycle_count(cntA));

  bip_fetch_control #(.CNT_WIDTH(4)) dutB (
    .clk(clk), .rst(rst), .start(startB), .prog_addr(progAddrB), .prog_rd(progRdB),
    .prog_data(progDataB), .wr_pc(wrPcB), .opcode(opcodeB), .operand(operandB),
    .instr_valid(instrValidB), .busy(busyB), .halted(haltedB), .cycle_count(cntB));

  // synchronous program memories and decoder models
  always @(posedge clk) if (progRdA) progDataA <= memA[progAddrA];
  always @(posedge clk) if (progRdB) progDataB <= memB[progAddrB[2:0]];
  assign wrPcA = !stallA && (opcodeA != 5'd0);
  assign wrPcB = (opcodeB != 5'd0);

  ev_t addrQ[$];
  ev_t opQ[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [15:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!rst && progRdA) begin
      if (addrQ.size() == 0) chk("fetch_unexpected", 32'(progRdA), 32'd0);
      else begin
        e = addrQ.pop_front();
        chk("fetch_addr", 32'(progAddrA), 32'(e.val));
        chk("fetch_cycle", 32'(cyc - baseA), 32'(e.cyc));
      end
    end
    if (!rst && instrValidA) begin
      if (opQ.size() == 0) chk("exec_unexpected", 32'(instrValidA), 32'd0);
      else begin
        e = opQ.pop_front();
        chk("exec_opcode", 32'(opcodeA), 32'(e.val));
        chk("exec_cycle", 32'(cyc - baseA), 32'(e.cyc));
      end
    end
  end

  task automatic loadProg3();
    memA[0] = 16'h1805; memA[1] = 16'h2803; memA[2] = 16'h0000;
    for (int i = 3; i < 8; i++) memA[i] = 16'h0000;
  endtask

  task automatic pushProg3();
    addrQ.push_back(mk(0, 16'd0)); addrQ.push_back(mk(3, 16'd1)); addrQ.push_back(mk(6, 16'd2));
    opQ.push_back(mk(2, 16'd3));   opQ.push_back(mk(5, 16'd5));   opQ.push_back(mk(8, 16'd0));
  endtask

  // leaves the bench at the negedge inside cycle 0 (the FETCH cycle)
  task automatic startRunA();
    @(negedge clk);
    startA = 1'b1;
    baseA  = cyc + 1;
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic waitHaltA(input string tag);
    for (int i = 0; i < 60 && !haltedA; i++) @(negedge clk);
    chk(tag, 32'(haltedA), 32'd1);
  endtask

  task automatic queuesEmpty(input string tag);
    chk({tag, "_addrq"}, 32'(addrQ.size()), 32'd0);
    chk({tag, "_opq"}, 32'(opQ.size()), 32'd0);
  endtask

  initial begin
    loadProg3();
    for (int i = 0; i < 8; i++) memB[i] = (i < 5) ? 16'h2801 : 16'h0000;

    // reset state
    @(negedge clk);
    chk("rst_prog_rd", 32'(progRdA), 32'd0);
    chk("rst_busy", 32'(busyA), 32'd0);
    chk("rst_halted", 32'(haltedA), 32'd0);
    chk("rst_addr", 32'(progAddrA), 32'd0);
    chk("rst_count", cntA, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_fetch", 32'(progRdA), 32'd0);

    // three-instruction program, start pulse
    pushProg3();
    startRunA();
    chk("t1_count_c0", cntA, 32'd0);
    repeat (8) @(negedge clk);
    chk("t1_not_halted_c8", 32'(haltedA), 32'd0);
    chk("t1_busy_c8", 32'(busyA), 32'd1);
    @(negedge clk);
    chk("t1_halted_c9", 32'(haltedA), 32'd1);
    chk("t1_busy_c9", 32'(busyA), 32'd0);
    chk("t1_count", cntA, 32'd9);
    chk("t1_pc", 32'(progAddrA), 32'd2);
    repeat (3) @(negedge clk);
    chk("t1_count_frozen", cntA, 32'd9);
    chk("t1_still_halted", 32'(haltedA), 32'd1);
    queuesEmpty("t1");

    // start held high for the whole run
    pushProg3();
    @(negedge clk);
    startA = 1'b1;
    baseA  = cyc + 1;
    @(negedge clk);
    waitHaltA("t2_halt");
    startA = 1'b0;
    chk("t2_halt_cycle", 32'(cyc - baseA), 32'd9);
    chk("t2_count", cntA, 32'd9);
    queuesEmpty("t2");

    // restart from HALT
    pushProg3();
    startRunA();
    chk("t2r_count_cleared", cntA, 32'd0);
    waitHaltA("t2r_halt");
    chk("t2r_count", cntA, 32'd9);
    queuesEmpty("t2r");

    // PC wrap with PC_WIDTH=3
    for (int i = 0; i < 8; i++) memA[i] = 16'h2801;
    for (int k = 0; k < 9; k++) addrQ.push_back(mk(3 * k, 16'(k % 8)));
    for (int k = 0; k < 8; k++) opQ.push_back(mk(3 * k + 2, 16'd5));
    startRunA();
    repeat (24) @(negedge clk);
    chk("t3_count_refetch0", cntA, 32'd24);
    chk("t3_addr_wrapped", 32'(progAddrA), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    queuesEmpty("t3");

    // wr_pc held low: address 0 refetched forever
    stallA = 1'b1;
    for (int k = 0; k < 5; k++) addrQ.push_back(mk(3 * k, 16'd0));
    for (int k = 0; k < 4; k++) opQ.push_back(mk(3 * k + 2, 16'd5));
    startRunA();
    repeat (12) @(negedge clk);
    chk("t4_addr_held", 32'(progAddrA), 32'd0);
    chk("t4_count", cntA, 32'd12);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stallA = 1'b0;
    queuesEmpty("t4");

    // asynchronous reset during WAIT of instruction 1
    loadProg3();
    addrQ.push_back(mk(0, 16'd0)); addrQ.push_back(mk(3, 16'd1));
    opQ.push_back(mk(2, 16'd3));
    startRunA();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_prog_rd", 32'(progRdA), 32'd0);
    chk("t5_instr_valid", 32'(instrValidA), 32'd0);
    chk("t5_busy", 32'(busyA), 32'd0);
    chk("t5_halted", 32'(haltedA), 32'd0);
    chk("t5_opcode", 32'(opcodeA), 32'd0);
    chk("t5_operand", 32'(operandA), 32'd0);
    chk("t5_addr", 32'(progAddrA), 32'd0);
    chk("t5_count", cntA, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_idle_prog_rd", 32'(progRdA), 32'd0);
    end
    chk("t5_idle_opcode", 32'(opcodeA), 32'd0);
    queuesEmpty("t5");

    // 4-bit counter saturation on a 6-instruction program
    @(negedge clk);
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    repeat (16) @(negedge clk);
    chk("t6_count_sat", 32'(cntB), 32'd15);
    chk("t6_busy", 32'(busyB), 32'd1);
    for (int i = 0; i < 20 && !haltedB; i++) @(negedge clk);
    chk("t6_halt", 32'(haltedB), 32'd1);
    chk("t6_count_halt", 32'(cntB), 32'd15);
    chk("t6_pc", 32'(progAddrB), 32'd5);
    repeat (3) @(negedge clk);
    chk("t6_count_frozen", 32'(cntB), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
